// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access stage with a byte-enabled request/grant/response data bus.
// It aligns and extends load data and registers the MEM/WB pipeline stage. Define MEM_TIMEOUT_EN to add the bus watchdog.
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RegWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [4:0]  RdM,
    input  logic [31:0] PcPlus4M,
    input  logic [31:0] alu_outM,
    input  logic [31:0] WriteDataM,
    input  logic [2:0]  MemReadM,
    input  logic [2:0]  MemWriteM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        stall_M,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [4:0]  RdW,
    output logic [31:0] PcPlus4W,
    output logic [31:0] alu_outW,
    output logic [31:0] ReadDataW,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic [1:0]  o_fsm_state
);

    // Bus handshake: a request transfers in any cycle where dmem_req && dmem_gnt. While it waits for
    // gnt, addr/be/wdata/we stay stable. Load data follows on dmem_rvalid, at the earliest one cycle after the grant, and cannot be back-pressured.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_GNT = 2'd1,
        ST_WAIT_RSP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_sz_byte;
    logic        w_sz_half;
    logic        w_sz_word;
    logic        w_unsigned;
    logic        w_misalign;
    logic        w_mem_op;
    logic        w_req;
    logic        w_done;
    logic        w_abort;
    logic        w_timeout;
    logic        w_stall;
    logic        w_bubble;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_ld_shift;
    logic [31:0] w_ld_data;
    logic        r_misalign;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("mem_stage: TIMEOUT_CYCLES must be at least 2");
    end

    // Codes outside the defined load/store sets decode as "no memory op"; a load wins over a store.
    assign w_is_load  = (MemReadM >= 3'd1) && (MemReadM <= 3'd5);
    assign w_is_store = !w_is_load && (MemWriteM >= 3'd1) && (MemWriteM <= 3'd3);
    assign w_sz_byte  = (w_is_load && (MemReadM == 3'd1 || MemReadM == 3'd4)) ||
                        (w_is_store && MemWriteM == 3'd1);
    assign w_sz_half  = (w_is_load && (MemReadM == 3'd2 || MemReadM == 3'd5)) ||
                        (w_is_store && MemWriteM == 3'd2);
    assign w_sz_word  = (w_is_load && MemReadM == 3'd3) || (w_is_store && MemWriteM == 3'd3);
    assign w_unsigned = w_is_load && (MemReadM == 3'd4 || MemReadM == 3'd5);
    assign w_misalign = (w_sz_half && alu_outM[0]) || (w_sz_word && (alu_outM[1:0] != 2'b00));
    assign w_mem_op   = (w_is_load || w_is_store) && !w_misalign;

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = WriteDataM;
        if (w_sz_byte) begin
            w_be    = 4'b0001 << alu_outM[1:0];
            w_wdata = {4{WriteDataM[7:0]}};
        end else if (w_sz_half) begin
            w_be    = 4'b0011 << alu_outM[1:0];
            w_wdata = {2{WriteDataM[15:0]}};
        end else if (w_sz_word) begin
            w_be    = 4'b1111;
        end
    end

    assign w_ld_shift = dmem_rdata >> {alu_outM[1:0], 3'b000};

    always_comb begin
        w_ld_data = w_ld_shift;
        if (w_sz_byte) begin
            w_ld_data = {{24{!w_unsigned && w_ld_shift[7]}}, w_ld_shift[7:0]};
        end else if (w_sz_half) begin
            w_ld_data = {{16{!w_unsigned && w_ld_shift[15]}}, w_ld_shift[15:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_req   = 1'b0;
        w_done  = 1'b0;
        w_abort = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_mem_op) begin
                    w_req = 1'b1;
                    if (!dmem_gnt) begin
                        w_next = ST_WAIT_GNT;
                    end else if (w_is_load) begin
                        w_next = ST_WAIT_RSP;
                    end else begin
                        w_done = 1'b1;
                    end
                end
            end
            ST_WAIT_GNT: begin
                w_req = 1'b1;
                if (dmem_gnt) begin
                    if (w_is_load) begin
                        w_next = ST_WAIT_RSP;
                    end else begin
                        w_done = 1'b1;
                        w_next = ST_IDLE;
                    end
                end else if (w_timeout) begin
                    w_abort = 1'b1;
                    w_next  = ST_IDLE;
                end
            end
            ST_WAIT_RSP: begin
                if (dmem_rvalid) begin
                    w_done = 1'b1;
                    w_next = ST_IDLE;
                end else if (w_timeout) begin
                    w_abort = 1'b1;
                    w_next  = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned      LP_CW   = $clog2(TIMEOUT_CYCLES);
    localparam logic [LP_CW-1:0] LP_LAST = LP_CW'(TIMEOUT_CYCLES - 1);

    logic [LP_CW-1:0] r_wait_cnt;
    logic             r_bus_err;

    // Any state change restarts the count, so each wait state gets its own full budget.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
            r_bus_err  <= 1'b0;
        end else begin
            r_bus_err <= w_abort;
            if (r_state != w_next) begin
                r_wait_cnt <= '0;
            end else if (r_state != ST_IDLE) begin
                r_wait_cnt <= r_wait_cnt + LP_CW'(1);
            end
        end
    end

    assign w_timeout = (r_state != ST_IDLE) && (r_wait_cnt == LP_LAST);
    assign bus_err_o = r_bus_err;
`else
    assign w_timeout = 1'b0;
    assign bus_err_o = 1'b0;
`endif

    // Bus-side outputs are forced quiet while reset is held, even if EX/MEM still presents an op.
    assign w_stall     = ((r_state != ST_IDLE) || w_mem_op) && !w_done && !w_abort;
    assign w_bubble    = w_stall || w_abort || ((r_state == ST_IDLE) && w_misalign);
    assign stall_M     = rst_n && w_stall;
    assign dmem_req    = rst_n && w_req;
    assign dmem_we     = dmem_req && w_is_store;
    assign dmem_be     = dmem_req ? w_be : 4'b0000;
    assign dmem_addr   = {alu_outM[31:2], 2'b00};
    assign dmem_wdata  = w_wdata;
    assign misalign_o  = r_misalign;
    assign o_fsm_state = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            RdW        <= 5'd0;
            PcPlus4W   <= 32'd0;
            alu_outW   <= 32'd0;
            ReadDataW  <= 32'd0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= (r_state == ST_IDLE) && w_misalign;
            if (w_bubble) begin
                RegWriteW <= 1'b0;
                RdW       <= 5'd0;
            end else begin
                RegWriteW  <= RegWriteM;
                ResultSrcW <= ResultSrcM;
                RdW        <= RdM;
                PcPlus4W   <= PcPlus4M;
                alu_outW   <= alu_outM;
                ReadDataW  <= w_is_load ? w_ld_data : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage (stores, loads, misalignment, reset abort).
// With MEM_TIMEOUT_EN defined it also exercises the bus watchdog at TIMEOUT_CYCLES=8.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RdM;
    logic [31:0] PcPlus4M;
    logic [31:0] alu_outM;
    logic [31:0] WriteDataM;
    logic [2:0]  MemReadM;
    logic [2:0]  MemWriteM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        stall_M;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RdW;
    logic [31:0] PcPlus4W;
    logic [31:0] alu_outW;
    logic [31:0] ReadDataW;
    logic        misalign_o;
    logic        bus_err_o;
    logic [1:0]  o_fsm_state;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    mem_stage #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .RdM(RdM), .PcPlus4M(PcPlus4M),
        .alu_outM(alu_outM), .WriteDataM(WriteDataM), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .stall_M(stall_M), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
        .PcPlus4W(PcPlus4W), .alu_outW(alu_outW), .ReadDataW(ReadDataW),
        .misalign_o(misalign_o), .bus_err_o(bus_err_o), .o_fsm_state(o_fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        RegWriteM   = 1'b0;
        ResultSrcM  = 2'b00;
        RdM         = 5'd0;
        PcPlus4M    = 32'd0;
        alu_outM    = 32'd0;
        WriteDataM  = 32'd0;
        MemReadM    = 3'd0;
        MemWriteM   = 3'd0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'd0;
    endtask

    task automatic do_store(input string tag, input logic [2:0] wcode, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [3:0] exp_be, input logic [31:0] exp_wd);
        RegWriteM  = 1'b0;
        RdM        = 5'd0;
        alu_outM   = addr;
        WriteDataM = wd;
        MemWriteM  = wcode;
        dmem_gnt   = 1'b1;
        #1;
        check({tag, " req"}, dmem_req, 1);
        check({tag, " we"}, dmem_we, 1);
        check({tag, " addr"}, dmem_addr, {addr[31:2], 2'b00});
        check({tag, " be"}, dmem_be, exp_be);
        check({tag, " wdata"}, dmem_wdata, exp_wd);
        check({tag, " stall"}, stall_M, 0);
        tick();
        check({tag, " RegWriteW"}, RegWriteW, 0);
        check({tag, " state"}, o_fsm_state, 0);
        set_idle();
    endtask

    task automatic do_load(input string tag, input logic [2:0] rcode, input logic [2:0] wcode,
                           input logic [31:0] addr, input logic [31:0] rdata, input int gnt_dly,
                           input int rsp_dly, input logic [3:0] exp_be, input logic [31:0] exp_data);
        int last;
        int stalls;
        last       = gnt_dly + rsp_dly;
        stalls     = 0;
        RegWriteM  = 1'b1;
        ResultSrcM = 2'b01;
        RdM        = 5'd7;
        PcPlus4M   = 32'h0000_0200;
        alu_outM   = addr;
        WriteDataM = 32'hCAFE_F00D;
        MemReadM   = rcode;
        MemWriteM  = wcode;
        exp_q.push_back(exp_data);
        for (int c = 0; c <= last; c++) begin
            dmem_gnt    = (c == gnt_dly);
            dmem_rvalid = (c == last);
            dmem_rdata  = (c == last) ? rdata : 32'h5A5A_5A5A;
            #1;
            if (stall_M) stalls++;
            if (c <= gnt_dly) begin
                check({tag, " req"}, dmem_req, 1);
                check({tag, " we"}, dmem_we, 0);
                check({tag, " addr"}, dmem_addr, {addr[31:2], 2'b00});
                check({tag, " be"}, dmem_be, exp_be);
            end else begin
                check({tag, " req in rsp wait"}, dmem_req, 0);
            end
            tick();
            if (c < last) begin
                check({tag, " bubble"}, RegWriteW, 0);
                check({tag, " wait state"}, o_fsm_state, (c >= gnt_dly) ? 32'd2 : 32'd1);
            end
        end
        check({tag, " stall cycles"}, stalls, last);
        check({tag, " RegWriteW"}, RegWriteW, 1);
        check({tag, " RdW"}, RdW, 7);
        check({tag, " ResultSrcW"}, ResultSrcW, 1);
        check({tag, " PcPlus4W"}, PcPlus4W, 32'h0000_0200);
        check({tag, " ReadDataW"}, ReadDataW, exp_q.pop_front());
        check({tag, " state idle"}, o_fsm_state, 0);
        set_idle();
    endtask

    task automatic do_misalign(input string tag, input logic [2:0] rcode, input logic [2:0] wcode,
                               input logic [31:0] addr);
        RegWriteM = 1'b1;
        RdM       = 5'd12;
        alu_outM  = addr;
        MemReadM  = rcode;
        MemWriteM = wcode;
        dmem_gnt  = 1'b1;
        #1;
        check({tag, " req"}, dmem_req, 0);
        check({tag, " stall"}, stall_M, 0);
        tick();
        check({tag, " misalign pulse"}, misalign_o, 1);
        check({tag, " RegWriteW"}, RegWriteW, 0);
        set_idle();
        tick();
        check({tag, " misalign low"}, misalign_o, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst req", dmem_req, 0);
        check("rst we", dmem_we, 0);
        check("rst be", dmem_be, 0);
        check("rst stall", stall_M, 0);
        check("rst RegWriteW", RegWriteW, 0);
        check("rst ReadDataW", ReadDataW, 0);
        check("rst misalign", misalign_o, 0);
        check("rst bus_err", bus_err_o, 0);
        check("rst state", o_fsm_state, 0);
        rst_n = 1'b1;
        tick();

        // non-memory op passes in one cycle
        RegWriteM  = 1'b1;
        ResultSrcM = 2'b10;
        RdM        = 5'd5;
        PcPlus4M   = 32'h0000_0104;
        alu_outM   = 32'h0000_1234;
        #1;
        check("alu req", dmem_req, 0);
        check("alu stall", stall_M, 0);
        tick();
        check("alu RegWriteW", RegWriteW, 1);
        check("alu RdW", RdW, 5);
        check("alu ResultSrcW", ResultSrcW, 2);
        check("alu PcPlus4W", PcPlus4W, 32'h0000_0104);
        check("alu alu_outW", alu_outW, 32'h0000_1234);
        check("alu ReadDataW", ReadDataW, 0);
        set_idle();
        tick();

        do_store("SB", 3'd1, 32'h0000_1003, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5);
        do_store("SH", 3'd2, 32'h0000_2002, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF);
        do_store("SW", 3'd3, 32'h0000_2004, 32'h1234_BEEF, 4'b1111, 32'h1234_BEEF);

        do_load("LB", 3'd1, 3'd0, 32'h0000_2002, 32'h0080_0000, 0, 1, 4'b0100, 32'hFFFF_FF80);
        do_load("LBU", 3'd4, 3'd0, 32'h0000_2002, 32'h0080_0000, 0, 1, 4'b0100, 32'h0000_0080);
        do_load("LB pos", 3'd1, 3'd0, 32'h0000_2003, 32'h7F00_0000, 0, 1, 4'b1000, 32'h0000_007F);
        do_load("LH slow", 3'd2, 3'd0, 32'h0000_4002, 32'h8001_1234, 3, 2, 4'b1100, 32'hFFFF_8001);
        do_load("LHU", 3'd5, 3'd0, 32'h0000_4000, 32'h1234_F00D, 1, 1, 4'b0011, 32'h0000_F00D);
        do_load("LW", 3'd3, 3'd0, 32'h0000_4000, 32'hDEAD_BEEF, 0, 3, 4'b1111, 32'hDEAD_BEEF);
        do_load("LW over SW", 3'd3, 3'd3, 32'h0000_7000, 32'h0123_4567, 0, 1, 4'b1111, 32'h0123_4567);

        do_misalign("LW mis", 3'd3, 3'd0, 32'h0000_3002);
        do_misalign("SH mis", 3'd0, 3'd2, 32'h0000_1001);

        // undefined read code behaves as no memory op
        RegWriteM = 1'b1;
        RdM       = 5'd3;
        alu_outM  = 32'h0000_0055;
        PcPlus4M  = 32'h0000_0044;
        MemReadM  = 3'b110;
        #1;
        check("badcode req", dmem_req, 0);
        check("badcode stall", stall_M, 0);
        tick();
        check("badcode RegWriteW", RegWriteW, 1);
        check("badcode alu_outW", alu_outW, 32'h0000_0055);
        check("badcode ReadDataW", ReadDataW, 0);

        // reset while a load waits for its response; PcPlus4W still holds 0x44
        RegWriteM = 1'b1;
        RdM       = 5'd9;
        alu_outM  = 32'h0000_6000;
        MemReadM  = 3'd3;
        dmem_gnt  = 1'b1;
        tick();
        check("rstmid wait_rsp", o_fsm_state, 2);
        dmem_gnt = 1'b0;
        #1;
        check("rstmid stall before", stall_M, 1);
        rst_n = 1'b0;
        #1;
        check("rstmid state", o_fsm_state, 0);
        check("rstmid stall", stall_M, 0);
        check("rstmid req", dmem_req, 0);
        check("rstmid be", dmem_be, 0);
        check("rstmid PcPlus4W", PcPlus4W, 0);
        set_idle();
        tick();
        rst_n       = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hFFFF_FFFF;
        tick();
        check("late rvalid RegWriteW", RegWriteW, 0);
        check("late rvalid ReadDataW", ReadDataW, 0);
        check("late rvalid state", o_fsm_state, 0);
        set_idle();
        tick();

`ifdef MEM_TIMEOUT_EN
        begin
            int waited;
            bit seen;
            bit last_stall;
            waited     = 0;
            seen       = 1'b0;
            last_stall = 1'b1;
            RegWriteM  = 1'b1;
            RdM        = 5'd4;
            alu_outM   = 32'h0000_5000;
            MemReadM   = 3'd3;
            for (int c = 0; c < 30 && !seen; c++) begin
                #1;
                last_stall = stall_M;
                tick();
                waited++;
                if (bus_err_o) seen = 1'b1;
            end
            set_idle();
            check("tmo bus_err seen", seen, 1);
            check("tmo cycles", waited, 9);
            check("tmo stall released", last_stall, 0);
            check("tmo RegWriteW", RegWriteW, 0);
            tick();
            check("tmo bus_err pulse", bus_err_o, 0);
        end
`else
        check("bus_err tied low", bus_err_o, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
